// File: rtl/aeolus_loader_pkg.sv
// Shared types and constants for the Aeolus program loader.
// Holds the loader state encoding, the default frame marker and the opcode geometry.
package aeolus_loader_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int NIBBLES_PER_BYTE = 8 / OPCODE_WIDTH;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        DATA,
        WRLO,
        CHECK,
        DONE
    } loader_state_t;

    // A length byte of zero encodes a full 256-opcode frame.
    function automatic logic [8:0] opcode_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader; restarts on demand and flags when the
// next idle edge would be the TIMEOUT_CYCLES-th one since the last restart.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || restart || !run) begin
            count_reg <= '0;
        end else if (count_reg != LAST_COUNT) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Saturating count means the flag holds until the owner restarts or stops us.
    assign terminal = run && !restart && (count_reg == LAST_COUNT);

endmodule

// File: rtl/program_loader.sv
// Frame receiver that unpacks opcode nibbles into program memory and holds
// the CPU in reset until a checksum-verified frame has been loaded.
module program_loader
    import aeolus_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    input  logic [7:0]              inData,
    output logic                    inReady,
    output logic                    wrEn,
    output logic [ADDR_WIDTH-1:0]   wrAddr,
    output logic [OPCODE_WIDTH-1:0] wrData,
    output logic                    cpuHold,
    output logic                    done,
    output logic                    error
);

    loader_state_t             state_reg;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic [8:0]                remain_reg;
    logic [7:0]                chk_reg;
    logic [OPCODE_WIDTH-1:0]   lo_reg;
    logic                      wr_en_reg;
    logic [ADDR_WIDTH-1:0]     wr_addr_reg;
    logic [OPCODE_WIDTH-1:0]   wr_data_reg;
    logic                      cpu_hold_reg;
    logic                      done_reg;
    logic                      error_reg;

    logic                      transfer;
    logic                      is_sync;
    logic                      to_run;
    logic                      to_terminal;
    logic                      timed_out;
    logic [OPCODE_WIDTH-1:0]   in_nibble [NIBBLES_PER_BYTE];

    // Index 0 is the high nibble, which always lands on the even address.
    generate
        for (genvar gi = 0; gi < NIBBLES_PER_BYTE; gi++) begin : g_unpack
            assign in_nibble[gi] = inData[7 - gi*OPCODE_WIDTH -: OPCODE_WIDTH];
        end
    endgenerate

    assign inReady  = (state_reg != WRLO);
    assign transfer = inValid && inReady;
    assign is_sync  = (inData == SYNC_BYTE);

    // WRLO keeps the counter alive so the idle span includes the low-nibble cycle,
    // but expiry is only honoured where abandoning the frame is safe.
    assign to_run    = (state_reg inside {LEN, DATA, WRLO, CHECK});
    assign timed_out = to_terminal && !transfer && (state_reg inside {LEN, DATA, CHECK});

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .run      (to_run),
        .restart  (transfer),
        .terminal (to_terminal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= HUNT;
            addr_reg     <= '0;
            remain_reg   <= '0;
            chk_reg      <= '0;
            lo_reg       <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                HUNT: begin
                    if (transfer && is_sync) begin
                        state_reg <= LEN;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                    end
                end
                LEN: begin
                    if (timed_out) begin
                        error_reg <= 1'b1;
                        state_reg <= HUNT;
                    end else if (transfer) begin
                        remain_reg <= opcode_count(inData);
                        addr_reg   <= '0;
                        chk_reg    <= '0;
                        state_reg  <= DATA;
                    end
                end
                DATA: begin
                    if (timed_out) begin
                        error_reg <= 1'b1;
                        state_reg <= HUNT;
                    end else if (transfer) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= addr_reg;
                        wr_data_reg <= in_nibble[0];
                        lo_reg      <= in_nibble[1];
                        addr_reg    <= addr_reg + ADDR_WIDTH'(1);
                        chk_reg     <= chk_reg ^ inData;
                        remain_reg  <= remain_reg - 9'd1;
                        state_reg   <= (remain_reg > 9'd1) ? WRLO : CHECK;
                    end
                end
                WRLO: begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= addr_reg;
                    wr_data_reg <= lo_reg;
                    addr_reg    <= addr_reg + ADDR_WIDTH'(1);
                    remain_reg  <= remain_reg - 9'd1;
                    state_reg   <= (remain_reg > 9'd1) ? DATA : CHECK;
                end
                CHECK: begin
                    if (timed_out) begin
                        error_reg <= 1'b1;
                        state_reg <= HUNT;
                    end else if (transfer) begin
                        if (inData == chk_reg) begin
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                            state_reg    <= DONE;
                        end else begin
                            error_reg <= 1'b1;
                            state_reg <= HUNT;
                        end
                    end
                end
                DONE: begin
                    if (transfer && is_sync) begin
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        error_reg    <= 1'b0;
                        state_reg    <= LEN;
                    end
                end
                default: begin
                    state_reg <= HUNT;
                end
            endcase
        end
    end

    assign wrEn    = wr_en_reg;
    assign wrAddr  = wr_addr_reg;
    assign wrData  = wr_data_reg;
    assign cpuHold = cpu_hold_reg;
    assign done    = done_reg;
    assign error   = error_reg;

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the Aeolus instruction-fetch path. It receives a framed byte stream over a valid/ready handshake, unpacks two 4-bit opcodes per byte, and writes them into the program memory that the CPU fetches from. It holds the CPU in reset until a frame with a correct checksum has been loaded. It sits between the board-side byte source (switch/serial front end) and the write port of the instruction RAM.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- ADDR_WIDTH, 8, program memory address width; only 8 is supported
- TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a frame
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-low
- inValid  in  1  byte source has data
- inData  in  8  byte value
- inReady  out  1  loader accepts a byte this cycle; a transfer occurs when inValid && inReady
- wrEn  out  1  program memory write strobe
- wrAddr  out  ADDR_WIDTH  write address
- wrData  out  4  opcode to write
- cpuHold  out  1  holds the CPU in reset while high
- done  out  1  last frame loaded and verified
- error  out  1  last frame failed (checksum or timeout)

## Operation
- Frame format: SYNC_BYTE, LEN, D[0..M-1], CHK.
  - N = opcode count = LEN, where LEN=0 means 256.
  - M = ceil(N/2).
  - CHK = XOR of all D bytes.
- Packing: D[k] high nibble goes to address 2k, low nibble to address 2k+1. When N is odd, the low nibble of the last byte is not written but is still included in CHK.
- States:
  - HUNT: consume bytes. Non-sync bytes are discarded. SYNC_BYTE goes to LEN and clears error and done.
  - LEN: latch N, clear the address counter and checksum, go to DATA.
  - DATA: accept D[k], write the high nibble, fold the byte into the checksum. If a low nibble is due, go to WRLO; otherwise go to CHECK once all M bytes are taken.
  - WRLO: inReady=0, write the low nibble, then go to DATA, or to CHECK after the last byte.
  - CHECK: accept CHK. On a match go to DONE (done=1, cpuHold=0). On a mismatch go to HUNT (error=1).
  - DONE: bytes other than SYNC_BYTE are consumed and ignored. SYNC_BYTE sets cpuHold=1 and goes to LEN.
- cpuHold=1 in every state except DONE.
- Timeout: an idle counter runs in LEN, DATA and CHECK. It restarts on every accepted byte. When it reaches TIMEOUT_CYCLES, the loader sets error=1 and goes to HUNT. A pending WRLO write is never abandoned.
- The address counter increments per written nibble. After 256 nibbles it wraps to 0, but no write follows the wrap.
- A failed frame leaves memory partially written. cpuHold stays 1.

## Timing
- Reset values: state HUNT, inReady=1, wrEn=0, wrAddr=0, wrData=0, cpuHold=1, done=0, error=0; counters 0.
- Reset mid-frame: on the next edge wrEn=0, and the loader reaches HUNT with no further writes.
- All outputs are registered except inReady, which is decoded from the state (0 only in WRLO).
- A byte accepted at edge t produces its high-nibble write with wrEn=1 during cycle t+1. The low-nibble write follows in cycle t+2, and inReady=0 during t+1.
- Throughput: 1 byte per 2 cycles for full bytes, 1 byte per cycle otherwise.
- CHK accepted at edge t gives done=1 / cpuHold=0, or error=1, in cycle t+1.
- The source must hold inValid and inData stable until the transfer. inValid asserted while inReady=0 transfers nothing.
- An idle count of TIMEOUT_CYCLES with no transfer flags error in the following cycle.

## Structure
- Shared package aeolus_loader_pkg holds:
  - the state enum (HUNT, LEN, DATA, WRLO, CHECK, DONE);
  - the default SYNC_BYTE;
  - OPCODE_WIDTH=4.
- Sub-module loader_timeout: idle counter with restart and terminal-count outputs, parameterised by TIMEOUT_CYCLES.
- Everything else (FSM, address/nibble counter, checksum register) lives in program_loader.

## Test plan
- Basic load: reset, then A5,03,12,30,22.
  - Writes (0,1), (1,2), (2,3); no write to address 3.
  - done=1 and cpuHold=0 one cycle after 22 is accepted.
- Checksum failure: A5,02,34,00.
  - Writes (0,3), (1,4).
  - error=1, done=0, cpuHold=1, state HUNT.
- Junk before sync: 00,FF,A5,02,5A,5A.
  - Junk bytes are discarded.
  - Writes (0,5), (1,A); done=1.
  - With inValid held high throughout, inReady=0 in each WRLO cycle and no byte is lost.
- Timeout: A5,02,11, then no further inValid.
  - error=1 exactly TIMEOUT_CYCLES cycles after byte 11 is accepted.
  - cpuHold=1.
- Full length: A5,00 followed by 128 bytes 00..7F and their XOR.
  - 256 writes; the final write is at address FF.
  - done=1, and no write occurs after address FF.
- Reset mid-frame and reload:
  - Assert reset during DATA: wrEn=0 next cycle, cpuHold=1.
  - Then load A5,01,70,70: write (0,7), done=1.
  - From DONE, a new A5 sets cpuHold=1 and clears done.
